// File: rtl/sd_pkg.sv
// Shared types and helpers for the SD socket pin debouncer.
package sd_pkg;

  typedef enum logic [1:0] {
    DBC_DISABLED,
    DBC_UNSTABLE,
    DBC_STABLE
  } debounce_state_e;

  // Debounce period that applies to the level currently being qualified.
  function automatic int unsigned dbc_period(input logic lvl, input int unsigned assert_p,
                                             input int unsigned deassert_p);
    return lvl ? assert_p : deassert_p;
  endfunction

endpackage

// File: rtl/sd_pin_debounce_ch.sv
// One pin channel: synchroniser, polarity, debounce FSM/counter and event pulses.
module sd_pin_debounce_ch
  import sd_pkg::*;
#(
  parameter int unsigned AssertPeriod   = 5000000,
  parameter int unsigned DeassertPeriod = 5000000,
  parameter bit          FastDeassert   = 1'b1,
  parameter int unsigned SyncStages     = 2,
  parameter bit          ActiveLow      = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pin_i,
  input  logic en_i,
  output logic stable_o,
  output logic state_o,
  output logic insert_o,
  output logic remove_o
);

  localparam int unsigned MaxPeriod = (AssertPeriod > DeassertPeriod) ? AssertPeriod
                                                                      : DeassertPeriod;
  localparam int unsigned CntW = $clog2(MaxPeriod + 1);

  logic pin_s;

  if (SyncStages == 0) begin : g_nosync
    assign pin_s = pin_i;
  end else begin : g_sync
    logic [SyncStages-1:0] sync_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        sync_q <= '0;
      end else begin
        sync_q[0] <= pin_i;
        for (int i = 1; i < SyncStages; i++) begin
          sync_q[i] <= sync_q[i-1];
        end
      end
    end
    assign pin_s = sync_q[SyncStages-1];
  end

  debounce_state_e st_q, st_d;
  logic [CntW-1:0] cnt_q, cnt_d, reload;
  logic            level_q, lvl, change;
  logic            state_q, state_d, pend_q, pend_d;
  logic            ins_q, ins_d, rm_q, rm_d;
  logic            state_eff;

  assign lvl       = pin_s ^ ActiveLow;
  assign change    = lvl != level_q;
  assign reload    = CntW'(dbc_period(lvl, AssertPeriod, DeassertPeriod) - 1);
  // A pending fast remove has already given up the asserted state.
  assign state_eff = state_q & ~pend_q;

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    pend_d  = 1'b0;
    ins_d   = 1'b0;
    rm_d    = 1'b0;
    if (!en_i) begin
      st_d    = DBC_DISABLED;
      state_d = 1'b0;
    end else if (st_q == DBC_DISABLED) begin
      st_d  = DBC_UNSTABLE;
      cnt_d = reload;
    end else begin
      if (pend_q) begin
        rm_d    = 1'b1;
        state_d = 1'b0;
      end
      if (change) begin
        st_d  = DBC_UNSTABLE;
        cnt_d = reload;
        if (FastDeassert && !lvl && state_eff) pend_d = 1'b1;
      end else if (st_q == DBC_UNSTABLE) begin
        if (cnt_q == '0) begin
          st_d = DBC_STABLE;
          if (lvl && !state_eff) begin
            ins_d   = 1'b1;
            state_d = 1'b1;
          end else if (!lvl && state_eff) begin
            rm_d    = 1'b1;
            state_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      st_q    <= DBC_UNSTABLE;
      cnt_q   <= CntW'(DeassertPeriod - 1);
      level_q <= 1'b0;
      state_q <= 1'b0;
      pend_q  <= 1'b0;
      ins_q   <= 1'b0;
      rm_q    <= 1'b0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      level_q <= lvl;
      state_q <= state_d;
      pend_q  <= pend_d;
      ins_q   <= ins_d;
      rm_q    <= rm_d;
    end
  end

  assign stable_o = (st_q == DBC_STABLE);
  assign state_o  = state_q;
  assign insert_o = ins_q;
  assign remove_o = rm_q;

endmodule

// File: rtl/sd_pin_debounce.sv
// Multi-channel SD socket pin debouncer with sticky W1C status and masked interrupt.
module sd_pin_debounce
  import sd_pkg::*;
#(
  parameter int unsigned          NumChannels    = 2,
  parameter int unsigned          AssertPeriod   = 5000000,
  parameter int unsigned          DeassertPeriod = 5000000,
  parameter bit                   FastDeassert   = 1'b1,
  parameter int unsigned          SyncStages     = 2,
  parameter logic [NumChannels-1:0] ActiveLow    = '0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NumChannels-1:0]   pin_i,
  input  logic [NumChannels-1:0]   en_i,
  input  logic [2*NumChannels-1:0] irq_mask_i,
  input  logic [2*NumChannels-1:0] clear_i,
  output logic [NumChannels-1:0]   stable_o,
  output logic [NumChannels-1:0]   state_o,
  output logic [NumChannels-1:0]   insert_o,
  output logic [NumChannels-1:0]   remove_o,
  output logic [2*NumChannels-1:0] status_o,
  output logic                     irq_o
);

  for (genvar i = 0; i < NumChannels; i++) begin : g_ch
    sd_pin_debounce_ch #(
      .AssertPeriod  (AssertPeriod),
      .DeassertPeriod(DeassertPeriod),
      .FastDeassert  (FastDeassert),
      .SyncStages    (SyncStages),
      .ActiveLow     (ActiveLow[i])
    ) u_ch (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .pin_i   (pin_i[i]),
      .en_i    (en_i[i]),
      .stable_o(stable_o[i]),
      .state_o (state_o[i]),
      .insert_o(insert_o[i]),
      .remove_o(remove_o[i])
    );
  end

  logic [2*NumChannels-1:0] status_q, status_d;
  logic                     irq_q;

  // New events win over a simultaneous clear so none are lost.
  assign status_d = (status_q & ~clear_i) | {remove_o, insert_o};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      status_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      status_q <= status_d;
      irq_q    <= |(status_q & irq_mask_i);
    end
  end

  assign status_o = status_q;
  assign irq_o    = irq_q;

endmodule

// File: tb/tb_sd_pin_debounce.sv
// Bench for sd_pin_debounce: fast- and slow-deassert instances against a run-length model.
module tb_sd_pin_debounce;

  localparam int unsigned APer = 4;
  localparam int unsigned DPer = 6;
  localparam logic [1:0]  AL   = 2'b10;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] pin, en;
  logic [3:0] mask, clr;

  logic [1:0] stable_w [2];
  logic [1:0] state_w  [2];
  logic [1:0] ins_w    [2];
  logic [1:0] rm_w     [2];
  logic [3:0] status_w [2];
  logic       irq_w    [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sd_pin_debounce #(
    .NumChannels(2), .AssertPeriod(APer), .DeassertPeriod(DPer),
    .FastDeassert(1'b1), .SyncStages(2), .ActiveLow(AL)
  ) u_dut_fast (
    .clk_i(clk), .rst_i(rst), .pin_i(pin), .en_i(en), .irq_mask_i(mask), .clear_i(clr),
    .stable_o(stable_w[0]), .state_o(state_w[0]), .insert_o(ins_w[0]),
    .remove_o(rm_w[0]), .status_o(status_w[0]), .irq_o(irq_w[0])
  );

  sd_pin_debounce #(
    .NumChannels(2), .AssertPeriod(APer), .DeassertPeriod(DPer),
    .FastDeassert(1'b0), .SyncStages(2), .ActiveLow(AL)
  ) u_dut_slow (
    .clk_i(clk), .rst_i(rst), .pin_i(pin), .en_i(en), .irq_mask_i(mask), .clear_i(clr),
    .stable_o(stable_w[1]), .state_o(state_w[1]), .insert_o(ins_w[1]),
    .remove_o(rm_w[1]), .status_o(status_w[1]), .irq_o(irq_w[1])
  );

  // Reference model: index 0 = fast deassert, 1 = slow deassert.
  logic [1:0] m_stable [2], m_state [2], m_ins [2], m_rm [2];
  logic [3:0] m_status [2];
  logic       m_irq    [2];
  int         m_run    [2][2];
  logic       m_prev   [2][2], m_dis [2][2], m_pend [2][2];
  logic [1:0] m_pipe   [2];

  task automatic model_reset();
    m_pipe[0] = '0;
    m_pipe[1] = '0;
    for (int d = 0; d < 2; d++) begin
      m_stable[d] = '0; m_state[d] = '0; m_ins[d] = '0; m_rm[d] = '0;
      m_status[d] = '0; m_irq[d] = 1'b0;
      for (int c = 0; c < 2; c++) begin
        m_run[d][c] = 1; m_prev[d][c] = 1'b0; m_dis[d][c] = 1'b0; m_pend[d][c] = 1'b0;
      end
    end
  endtask

  // Qualification rule: a level is accepted once seen on period+1 consecutive edges.
  task automatic model_step();
    logic       lv, nirq;
    logic [3:0] nstat;
    logic [1:0] ins, rm;
    if (rst) begin
      model_reset();
      return;
    end
    for (int d = 0; d < 2; d++) begin
      nirq  = |(m_status[d] & mask);
      nstat = (m_status[d] & ~clr) | {m_rm[d], m_ins[d]};
      ins = '0;
      rm  = '0;
      for (int c = 0; c < 2; c++) begin
        lv = m_pipe[1][c] ^ AL[c];
        if (!en[c]) begin
          m_dis[d][c] = 1'b1; m_stable[d][c] = 1'b0; m_state[d][c] = 1'b0;
          m_pend[d][c] = 1'b0;
        end else if (m_dis[d][c]) begin
          m_dis[d][c] = 1'b0;
          m_run[d][c] = 1;
        end else begin
          if (m_pend[d][c]) begin
            rm[c] = 1'b1; m_state[d][c] = 1'b0; m_pend[d][c] = 1'b0;
          end
          if (lv != m_prev[d][c]) begin
            m_run[d][c] = 1;
            m_stable[d][c] = 1'b0;
            if (d == 0 && !lv && m_state[d][c]) m_pend[d][c] = 1'b1;
          end else if (!m_stable[d][c]) begin
            m_run[d][c]++;
            if (m_run[d][c] == int'(lv ? APer : DPer) + 1) begin
              m_stable[d][c] = 1'b1;
              if (lv && !m_state[d][c]) begin
                ins[c] = 1'b1; m_state[d][c] = 1'b1;
              end else if (!lv && m_state[d][c]) begin
                rm[c] = 1'b1; m_state[d][c] = 1'b0;
              end
            end
          end
        end
        m_prev[d][c] = lv;
      end
      m_ins[d]    = ins;
      m_rm[d]     = rm;
      m_status[d] = nstat;
      m_irq[d]    = nirq;
    end
    m_pipe[1] = m_pipe[0];
    m_pipe[0] = pin;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic clear_all();
    clr = 4'hf;
    tick();
    clr = 4'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    #1;
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if ({stable_w[d], state_w[d], ins_w[d], rm_w[d], status_w[d], irq_w[d]} !== 13'd0) begin
        n_fail++;
        $display("FAIL reset dut%0d outputs got %b want all zero", d,
                 {stable_w[d], state_w[d], ins_w[d], rm_w[d], status_w[d], irq_w[d]});
      end
    end
    repeat (2) tick();
    rst = 1'b0;
    repeat (20) tick();
  endtask

  task automatic test_clean_insert();
    clear_all();
    mask = 4'hf;
    pin[0] = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        n_tests++;
        if (ins_w[d][0] !== (k == 6) || state_w[d][0] !== (k >= 6)
            || stable_w[d][0] !== (k < 2 || k >= 6)) begin
          n_fail++;
          $display("FAIL clean_insert dut%0d k=%0d ins/state/stable got %b%b%b want %b%b%b",
                   d, k, ins_w[d][0], state_w[d][0], stable_w[d][0],
                   k == 6, k >= 6, k < 2 || k >= 6);
        end
        if (k == 7) begin
          n_tests++;
          if (status_w[d][0] !== 1'b1) begin
            n_fail++;
            $display("FAIL clean_insert_status dut%0d got %b want 1", d, status_w[d][0]);
          end
        end
        if (k == 8) begin
          n_tests++;
          if (irq_w[d] !== 1'b1) begin
            n_fail++;
            $display("FAIL clean_insert_irq dut%0d got %b want 1", d, irq_w[d]);
          end
        end
      end
    end
  endtask

  task automatic test_fast_remove();
    pin[0] = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      tick();
      n_tests++;
      if (rm_w[0][0] !== (k == 3) || state_w[0][0] !== (k < 3)
          || stable_w[0][0] !== (k < 2 || k >= 8)) begin
        n_fail++;
        $display("FAIL fast_remove k=%0d rm/state/stable got %b%b%b want %b%b%b", k,
                 rm_w[0][0], state_w[0][0], stable_w[0][0], k == 3, k < 3, k < 2 || k >= 8);
      end
      n_tests++;
      if (rm_w[1][0] !== (k == 8) || state_w[1][0] !== (k < 8)) begin
        n_fail++;
        $display("FAIL slow_remove k=%0d rm/state got %b%b want %b%b", k,
                 rm_w[1][0], state_w[1][0], k == 8, k < 8);
      end
    end
    repeat (5) tick();
  endtask

  task automatic test_bounce();
    for (int t = 0; t < 4; t++) begin
      pin[0] = (t % 2 == 0);
      repeat (2) begin
        tick();
        for (int d = 0; d < 2; d++) begin
          n_tests++;
          if (ins_w[d][0] !== 1'b0 || rm_w[d][0] !== 1'b0) begin
            n_fail++;
            $display("FAIL bounce_quiet dut%0d t=%0d ins/rm got %b%b want 00", d, t,
                     ins_w[d][0], rm_w[d][0]);
          end
        end
      end
    end
    pin[0] = 1'b1;
    for (int k = 0; k <= 7; k++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        n_tests++;
        if (ins_w[d][0] !== (k == 6)) begin
          n_fail++;
          $display("FAIL bounce_insert dut%0d k=%0d got %b want %b", d, k, ins_w[d][0], k == 6);
        end
      end
    end
  endtask

  task automatic test_active_low();
    pin[1] = 1'b0;
    for (int k = 0; k <= 7; k++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        n_tests++;
        if (ins_w[d][1] !== (k == 6) || ins_w[d][0] !== 1'b0 || rm_w[d][0] !== 1'b0) begin
          n_fail++;
          $display("FAIL active_low dut%0d k=%0d ins1/ins0/rm0 got %b%b%b want %b00", d, k,
                   ins_w[d][1], ins_w[d][0], rm_w[d][0], k == 6);
        end
      end
    end
    pin[1] = 1'b1;
    repeat (12) tick();
  endtask

  task automatic test_clear();
    pin[0] = 1'b0;
    repeat (15) tick();
    clear_all();
    mask   = 4'b0001;
    pin[0] = 1'b1;
    for (int k = 0; k <= 9; k++) begin
      tick();
      clr = (k == 6 || k == 7) ? 4'b0001 : 4'b0000;
      for (int d = 0; d < 2; d++) begin
        n_tests++;
        if ((k == 6 && ins_w[d][0] !== 1'b1) || (k == 7 && status_w[d][0] !== 1'b1)
            || (k == 8 && (status_w[d][0] !== 1'b0 || irq_w[d] !== 1'b1))
            || (k == 9 && irq_w[d] !== 1'b0)) begin
          n_fail++;
          $display("FAIL clear dut%0d k=%0d ins/status0/irq got %b%b%b", d, k,
                   ins_w[d][0], status_w[d][0], irq_w[d]);
        end
      end
    end
    clr = 4'h0;
  endtask

  task automatic test_rst_mid();
    pin[0] = 1'b0;
    repeat (15) tick();
    pin[0] = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    model_reset();
    #1;
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if ({stable_w[d], state_w[d], ins_w[d], rm_w[d], status_w[d], irq_w[d]} !== 13'd0) begin
        n_fail++;
        $display("FAIL rst_mid_zero dut%0d got %b want all zero", d,
                 {stable_w[d], state_w[d], ins_w[d], rm_w[d], status_w[d], irq_w[d]});
      end
    end
    repeat (2) tick();
    rst = 1'b0;
    for (int k = 0; k <= 7; k++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        n_tests++;
        if (ins_w[d][0] !== (k == 6) || rm_w[d][0] !== 1'b0) begin
          n_fail++;
          $display("FAIL rst_mid_restart dut%0d k=%0d ins/rm got %b%b want %b0", d, k,
                   ins_w[d][0], rm_w[d][0], k == 6);
        end
      end
    end
  endtask

  task automatic test_en_low();
    clear_all();
    en[0] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      pin[0] = (k % 4 < 2);
      tick();
      for (int d = 0; d < 2; d++) begin
        n_tests++;
        if (stable_w[d][0] !== 1'b0 || state_w[d][0] !== 1'b0 || ins_w[d][0] !== 1'b0
            || rm_w[d][0] !== 1'b0 || status_w[d][2] !== 1'b0) begin
          n_fail++;
          $display("FAIL en_low dut%0d k=%0d stb/st/ins/rm/stat got %b%b%b%b%b want 00000", d, k,
                   stable_w[d][0], state_w[d][0], ins_w[d][0], rm_w[d][0], status_w[d][2]);
        end
      end
    end
    pin[0] = 1'b1;
    repeat (4) tick();
    en[0] = 1'b1;
    for (int k = 0; k <= 6; k++) begin
      tick();
      for (int d = 0; d < 2; d++) begin
        n_tests++;
        if (ins_w[d][0] !== (k == 4)) begin
          n_fail++;
          $display("FAIL en_restart dut%0d k=%0d ins got %b want %b", d, k, ins_w[d][0], k == 4);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int c = 0; c < 2; c++) begin
        if ($urandom_range(0, 11) == 0) pin[c] = ~pin[c];
        if ($urandom_range(0, 199) == 0) en[c] = ~en[c];
      end
      clr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      if ($urandom_range(0, 63) == 0) mask = 4'($urandom);
      rst = ($urandom_range(0, 799) == 0);
      if (rst) model_reset();
      tick();
      for (int d = 0; d < 2; d++) begin
        n_tests++;
        if ({stable_w[d], state_w[d], ins_w[d], rm_w[d], status_w[d], irq_w[d]} !==
            {m_stable[d], m_state[d], m_ins[d], m_rm[d], m_status[d], m_irq[d]}) begin
          n_fail++;
          $display("FAIL random dut%0d cyc=%0d stb/st/ins/rm/stat/irq got %b want %b", d, cyc,
                   {stable_w[d], state_w[d], ins_w[d], rm_w[d], status_w[d], irq_w[d]},
                   {m_stable[d], m_state[d], m_ins[d], m_rm[d], m_status[d], m_irq[d]});
        end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    pin  = 2'b10;
    en   = 2'b11;
    mask = 4'h0;
    clr  = 4'h0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_clean_insert();
    test_fast_remove();
    test_bounce();
    test_active_low();
    test_clear();
    test_rst_mid();
    test_en_low();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
